// File: rtl/cdb_arbiter_if.sv
// Purpose: bundles FU writeback requests and CDB broadcast signals for the CDB arbiter.
// Latency: none, wires only.
// Backpressure: FUs hold req/payload until fu_grant; the CDB has no back-pressure.
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 4,
  parameter int CDB_PORTS = 2,
  parameter int PR_W      = 6,
  parameter int ROB_W     = 3
);
  logic [NUM_FU-1:0]          fu_req;
  logic [NUM_FU*ROB_W-1:0]    fu_rob_id;
  logic [NUM_FU*PR_W-1:0]     fu_pd;
  logic [NUM_FU*32-1:0]       fu_value;
  logic [NUM_FU-1:0]          fu_grant;
  logic [CDB_PORTS-1:0]       cdb_valid;
  logic [CDB_PORTS*ROB_W-1:0] cdb_rob_id;
  logic [CDB_PORTS*PR_W-1:0]  cdb_pd;
  logic [CDB_PORTS*32-1:0]    cdb_value;

  // Requester side: functional units plus the bus consumers.
  modport master (
    output fu_req, fu_rob_id, fu_pd, fu_value,
    input  fu_grant, cdb_valid, cdb_rob_id, cdb_pd, cdb_value
  );

  // Arbiter side.
  modport slave (
    input  fu_req, fu_rob_id, fu_pd, fu_value,
    output fu_grant, cdb_valid, cdb_rob_id, cdb_pd, cdb_value
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin share of CDB_PORTS broadcast ports among NUM_FU writeback requesters.
// Latency: grant is combinational; the granted result is broadcast one cycle later for one cycle.
// Backpressure: a losing FU holds its request until granted; flush withholds all grants.
// Optional feature macro: CDB_PERF_CNT_EN adds saturating conflict and broadcast counters.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int CDB_PORTS  = 2,
  parameter int PR_ENTRIES = 64,
  parameter int ROB_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  cdb_arbiter_if.slave      bus
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_bcast_cnt
`endif
);
  localparam int PR_W  = $clog2(PR_ENTRIES);
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic [NUM_FU-1:0]    grant;
  logic [CDB_PORTS-1:0] sel_vld;
  logic [PTR_W-1:0]     sel_idx [CDB_PORTS];
  int                   n_grant;
  int                   last_idx;
  int                   cand;
  logic                 hit;

  // Scan FUs from rr_ptr with wrap; the k-th requester found takes CDB port k.
  always_comb begin
    grant      = '0;
    sel_vld    = '0;
    n_grant    = 0;
    last_idx   = 0;
    cand       = 0;
    hit        = 1'b0;
    rr_ptr_nxt = rr_ptr;
    for (int p = 0; p < CDB_PORTS; p++) begin
      sel_idx[p] = '0;
    end
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_FU) begin
          cand = cand - NUM_FU;
        end
        hit = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
          if (i == cand) begin
            hit = bus.fu_req[i];
          end
        end
        if (hit && (n_grant < CDB_PORTS)) begin
          for (int p = 0; p < CDB_PORTS; p++) begin
            if (p == n_grant) begin
              sel_vld[p] = 1'b1;
              sel_idx[p] = PTR_W'(cand);
            end
          end
          for (int i = 0; i < NUM_FU; i++) begin
            if (i == cand) begin
              grant[i] = 1'b1;
            end
          end
          last_idx = cand;
          n_grant  = n_grant + 1;
        end
      end
      // The next scan starts just past the last winner so nobody starves.
      if (n_grant > 0) begin
        rr_ptr_nxt = (last_idx == NUM_FU - 1) ? '0 : PTR_W'(last_idx + 1);
      end
    end
  end

  assign bus.fu_grant = grant;

  // Broadcast stage: capture winners' payloads; idle ports keep stale data with valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      bus.cdb_valid  <= '0;
      bus.cdb_rob_id <= '0;
      bus.cdb_pd     <= '0;
      bus.cdb_value  <= '0;
    end else begin
      rr_ptr        <= rr_ptr_nxt;
      bus.cdb_valid <= sel_vld;
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (sel_vld[p]) begin
          for (int i = 0; i < NUM_FU; i++) begin
            if (sel_idx[p] == PTR_W'(i)) begin
              bus.cdb_rob_id[p*ROB_W +: ROB_W] <= bus.fu_rob_id[i*ROB_W +: ROB_W];
              bus.cdb_pd[p*PR_W +: PR_W]       <= bus.fu_pd[i*PR_W +: PR_W];
              bus.cdb_value[p*32 +: 32]        <= bus.fu_value[i*32 +: 32];
            end
          end
        end
      end
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [32:0] conflict_sum;
  logic [32:0] bcast_sum;

  assign conflict_sum = {1'b0, perf_conflict_cnt} + 33'd1;
  assign bcast_sum    = {1'b0, perf_bcast_cnt} + 33'($countones(sel_vld));

  // Saturating counters: oversubscribed cycles and broadcasts committed to the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
      perf_bcast_cnt    <= '0;
    end else begin
      if (!flush && ($countones(bus.fu_req) > CDB_PORTS)) begin
        perf_conflict_cnt <= conflict_sum[32] ? '1 : conflict_sum[31:0];
      end
      perf_bcast_cnt <= bcast_sum[32] ? '1 : bcast_sum[31:0];
    end
  end
`endif
endmodule
